reg_dump: RTL and testbench

Sequential read-out engine for the MIPS register file. On a start pulse it walks every architectural register through one register-file read port (the `read1`/`data1` pair) and streams each value out over a valid/ready handshake as an {index, data} word. This is the reader counterpart to the register file's write port. It sits beside the register file and feeds the GUI/debug path, replacing per-change file dumps with an on-demand, cycle-accurate snapshot stream.

---
 rtl/reg_dump.sv | 75 +++++++
 tb/tb_reg_dump.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// reg_dump: walks the register file through one read port and streams
// each register as an {index, data} word over a valid/ready handshake.
module reg_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [DATA_W-1:0]   data_q, data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        index_d = index_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: if (start) begin
                idx_d   = '0;
                state_d = S_READ;
            end
            S_READ: begin
                data_d  = rd_data;
                index_d = idx_q;
                state_d = S_SEND;
            end
            S_SEND: if (out_ready) begin
                // the terminal compare keeps the counter from ever wrapping
                state_d = (idx_q == LAST_IDX) ? S_DONE : S_READ;
                idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign out_valid = state_q == S_SEND;
    assign rd_addr   = (state_q == S_IDLE) ? '0 : idx_q;
    assign out_index = index_q;
    assign out_data  = data_q;
    assign out_last  = out_valid && (index_q == LAST_IDX);
endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed checks of reg_dump against a behavioural register file.
module tb_reg_dump;
    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 0, reset = 1, start = 0, out_ready = 1;
    logic busy, done, out_valid, out_last;
    logic [AW-1:0] rd_addr, out_index;
    logic [DW-1:0] rd_data, out_data;

    logic [DW-1:0] rf [N];
    logic          load = 0, we = 0;
    logic [AW-1:0] wa = 0;
    logic [DW-1:0] wd = 0;

    int checks = 0, errors = 0;

    reg_dump #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    assign rd_data = (rd_addr == 0) ? '0 : rf[rd_addr];

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < N; k++) rf[k] <= 32'hA500_0000 + 32'(k);
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    function automatic logic [DW-1:0] pre(int k);
        return (k == 0) ? 32'h0 : 32'hA500_0000 + 32'(k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; start = 0; load = 1;
        tick();
        load = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({busy, done, out_valid, out_last, rd_addr, out_index, out_data} !== '0) begin
                errors++;
                $display("FAIL reset cyc%0d busy=%b done=%b valid=%b last=%b addr=%0d idx=%0d data=%h required all 0",
                         i, busy, done, out_valid, out_last, rd_addr, out_index, out_data);
            end
        end
    endtask

    task automatic test_full_dump();
        int words = 0;
        start = 1; out_ready = 1;
        tick();
        start = 0;
        for (int c = 1; c <= 66; c++) begin
            logic v;
            int   k;
            v = (c % 2 == 0) && c >= 2 && c <= 64;
            k = (c - 2) / 2;
            checks++;
            if (busy !== (c <= 65) || done !== (c == 65) || out_valid !== v || out_last !== (c == 64)) begin
                errors++;
                $display("FAIL full_ctrl cyc%0d busy=%b done=%b valid=%b last=%b required %b %b %b %b",
                         c, busy, done, out_valid, out_last, c <= 65, c == 65, v, c == 64);
            end
            if (c % 2 == 1 && c <= 63) begin
                checks++;
                if (rd_addr !== AW'((c - 1) / 2)) begin
                    errors++;
                    $display("FAIL full_addr cyc%0d got %0d required %0d", c, rd_addr, (c - 1) / 2);
                end
            end
            if (v) begin
                words++;
                checks++;
                if (out_index !== AW'(k) || out_data !== pre(k)) begin
                    errors++;
                    $display("FAIL full_word cyc%0d got idx=%0d data=%h required idx=%0d data=%h",
                             c, out_index, out_data, k, pre(k));
                end
            end
            if (c < 66) tick();
        end
        checks++;
        if (words != 32) begin
            errors++;
            $display("FAIL full_count got %0d required 32", words);
        end
    endtask

    task automatic test_back_to_back();
        int words = 0, c = 0;
        start = 1;
        tick();
        start = 0;
        checks++;
        if (busy !== 1'b1 || rd_addr !== '0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b addr=%0d required busy=1 addr=0", busy, rd_addr);
        end
        while (busy && c < 200) begin
            if (out_valid && out_ready) words++;
            tick();
            c++;
        end
        checks++;
        if (words != 32 || c >= 200) begin
            errors++;
            $display("FAIL b2b_count got %0d words in %0d cycles required 32", words, c);
        end
    endtask

    task automatic test_backpressure();
        int words = 0, done_cyc = -1;
        start = 1;
        tick();
        start = 0;
        for (int c = 1; c <= 69; c++) begin
            out_ready = !(c >= 12 && c <= 14);
            if (c >= 12 && c <= 15) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== AW'(5) || out_data !== pre(5)) begin
                    errors++;
                    $display("FAIL bp_hold cyc%0d got valid=%b idx=%0d data=%h required 1 5 %h",
                             c, out_valid, out_index, out_data, pre(5));
                end
            end
            if (out_valid && out_ready) words++;
            if (done) done_cyc = c;
            tick();
        end
        out_ready = 1;
        checks++;
        if (done_cyc != 68 || words != 32) begin
            errors++;
            $display("FAIL bp_done got done_cyc=%0d words=%0d required 68 32", done_cyc, words);
        end
    endtask

    task automatic test_start_busy();
        int words = 0, dones = 0, done_cyc = -1;
        start = 1;
        tick();
        start = 0;
        for (int c = 1; c <= 67; c++) begin
            start = (c == 10 || c == 40);
            if (out_valid && out_ready) begin
                checks++;
                if (out_index !== AW'(words)) begin
                    errors++;
                    $display("FAIL sb_order got idx=%0d required %0d", out_index, words);
                end
                words++;
            end
            if (done) begin dones++; done_cyc = c; end
            tick();
        end
        start = 0;
        checks++;
        if (words != 32 || dones != 1 || done_cyc != 65 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_result got words=%0d dones=%0d done_cyc=%0d busy=%b required 32 1 65 0",
                     words, dones, done_cyc, busy);
        end
    endtask

    task automatic test_reset_mid();
        int words = 0, dones = 0, c = 0;
        start = 1;
        tick();
        start = 0;
        for (int i = 1; i < 20; i++) tick();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 21; i <= 26; i++) begin
            checks++;
            if ({busy, done, out_valid, out_last, rd_addr, out_index, out_data} !== '0) begin
                errors++;
                $display("FAIL rm_idle cyc%0d busy=%b done=%b valid=%b idx=%0d data=%h required all 0",
                         i, busy, done, out_valid, out_index, out_data);
            end
            tick();
        end
        start = 1;
        tick();
        start = 0;
        while (busy && c < 200) begin
            if (out_valid && out_ready) begin
                checks++;
                if (out_index !== AW'(words) || out_data !== pre(words)) begin
                    errors++;
                    $display("FAIL rm_word got idx=%0d data=%h required %0d %h",
                             out_index, out_data, words, pre(words));
                end
                words++;
            end
            if (done) dones++;
            tick();
            c++;
        end
        checks++;
        if (words != 32 || dones != 1 || c >= 200) begin
            errors++;
            $display("FAIL rm_count got words=%0d dones=%0d required 32 1", words, dones);
        end
    endtask

    task automatic test_concurrent();
        logic [DW-1:0] got [N];
        start = 1;
        tick();
        start = 0;
        for (int c = 1; c <= 66; c++) begin
            we = (c == 10 || c == 18);
            wa = (c == 10) ? AW'(3) : AW'(9);
            wd = (c == 10) ? 32'h1234_5678 : 32'hDEAD_BEEF;
            if (out_valid && out_ready) got[out_index] = out_data;
            tick();
        end
        we = 0;
        checks++;
        if (got[9] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL cw_idx9 got %h required deadbeef", got[9]);
        end
        checks++;
        if (got[3] !== pre(3)) begin
            errors++;
            $display("FAIL cw_idx3 got %h required %h", got[3], pre(3));
        end
        checks++;
        if (got[10] !== pre(10) || got[0] !== 32'h0) begin
            errors++;
            $display("FAIL cw_other got r10=%h r0=%h required %h 0", got[10], got[0], pre(10));
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_back_to_back();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_concurrent();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
